// File: rtl/branch_predictor_if.sv
// Branch predictor bundle: fetch lookup, EX resolution update, flush and status.
interface branch_predictor_if;
    logic [31:0] lookup_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic        flush_all;
    logic [31:0] miss_count;

    modport master (
        output lookup_pc, upd_en, upd_pc, upd_taken, upd_target,
        output upd_pred_taken, upd_pred_target, flush_all,
        input  pred_taken, pred_target, mispredict, miss_count
    );

    modport slave (
        input  lookup_pc, upd_en, upd_pc, upd_taken, upd_target,
        input  upd_pred_taken, upd_pred_target, flush_all,
        output pred_taken, pred_target, mispredict, miss_count
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating direction counters and a
// saturating misprediction counter.
module branch_predictor #(
    parameter int ENTRIES  = 16,
    parameter int CNT_BITS = 2
) (
    input  logic                CLK,
    input  logic                nRST,
    branch_predictor_if.slave   bp
);
    localparam int IDX_BITS = $clog2(ENTRIES);
    localparam int TAG_BITS = 30 - IDX_BITS;

    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
    localparam logic [CNT_BITS-1:0] CNT_WT  = CNT_BITS'(1) << (CNT_BITS - 1);
    localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_WT - CNT_BITS'(1);

    logic [ENTRIES-1:0]  valid_q, valid_d;
    logic [TAG_BITS-1:0] tag_q [ENTRIES];
    logic [TAG_BITS-1:0] tag_d [ENTRIES];
    logic [31:0]         tgt_q [ENTRIES];
    logic [31:0]         tgt_d [ENTRIES];
    logic [CNT_BITS-1:0] cnt_q [ENTRIES];
    logic [CNT_BITS-1:0] cnt_d [ENTRIES];
    logic [31:0]         miss_q, miss_d;

    logic [IDX_BITS-1:0] l_idx, u_idx;
    logic [TAG_BITS-1:0] l_tag, u_tag;
    logic                l_hit, u_hit, mp;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{bp.lookup_pc[1:0], bp.upd_pc[1:0]};

    assign l_idx = bp.lookup_pc[IDX_BITS+1:2];
    assign l_tag = bp.lookup_pc[31:IDX_BITS+2];
    assign u_idx = bp.upd_pc[IDX_BITS+1:2];
    assign u_tag = bp.upd_pc[31:IDX_BITS+2];

    assign l_hit = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    // Gated by nRST so the prediction is safe while reset is held
    assign bp.pred_taken  = nRST & l_hit & cnt_q[l_idx][CNT_BITS-1];
    assign bp.pred_target = bp.pred_taken ? tgt_q[l_idx]
                                          : bp.lookup_pc + 32'd4;

    assign mp = bp.upd_en &
                ((bp.upd_taken != bp.upd_pred_taken) |
                 (bp.upd_taken & bp.upd_pred_taken &
                  (bp.upd_target != bp.upd_pred_target)));
    assign bp.mispredict = mp;
    assign bp.miss_count = miss_q;

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        miss_d  = miss_q;
        if (bp.upd_en) begin
            if (u_hit) begin
                if (bp.upd_taken) begin
                    tgt_d[u_idx] = bp.upd_target;
                    if (cnt_q[u_idx] != CNT_MAX)
                        cnt_d[u_idx] = cnt_q[u_idx] + CNT_BITS'(1);
                end else if (cnt_q[u_idx] != '0) begin
                    cnt_d[u_idx] = cnt_q[u_idx] - CNT_BITS'(1);
                end
            end else if (bp.upd_taken) begin
                valid_d[u_idx] = 1'b1;
                tag_d[u_idx]   = u_tag;
                tgt_d[u_idx]   = bp.upd_target;
                cnt_d[u_idx]   = CNT_WT;
            end
        end
        if (bp.flush_all)
            valid_d = '0;
        if (mp && (miss_q != 32'hFFFF_FFFF))
            miss_d = miss_q + 32'd1;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            valid_q <= '0;
            miss_q  <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                cnt_q[i] <= CNT_WNT;
            end
        end else begin
            valid_q <= valid_d;
            miss_q  <= miss_d;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= tag_d[i];
                tgt_q[i] <= tgt_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed vector bench for branch_predictor (ENTRIES=16, CNT_BITS=2).
module tb_branch_predictor;
    logic CLK;
    logic nRST;

    branch_predictor_if bp ();

    branch_predictor #(.ENTRIES(16), .CNT_BITS(2)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bp   (bp)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        nrst;
        logic        flush;
        logic [31:0] lpc;
        logic        uen;
        logic [31:0] upc;
        logic        utk;
        logic [31:0] utgt;
        logic        upt;
        logic [31:0] uptgt;
        logic        e_pt;
        logic [31:0] e_tgt;
        logic        e_mp;
        logic [31:0] e_mc;
    } vec_t;

    int nvec;
    int nerr;

    function automatic vec_t mk(
        logic nrst, logic flush, logic [31:0] lpc,
        logic uen, logic [31:0] upc, logic utk, logic [31:0] utgt,
        logic upt, logic [31:0] uptgt,
        logic e_pt, logic [31:0] e_tgt, logic e_mp, logic [31:0] e_mc);
        vec_t v;
        v.nrst = nrst; v.flush = flush; v.lpc = lpc;
        v.uen = uen; v.upc = upc; v.utk = utk; v.utgt = utgt;
        v.upt = upt; v.uptgt = uptgt;
        v.e_pt = e_pt; v.e_tgt = e_tgt; v.e_mp = e_mp; v.e_mc = e_mc;
        return v;
    endfunction

    // Outputs are checked just before the edge, then the edge is taken
    task automatic step(input string name, input vec_t v);
        nRST               = v.nrst;
        bp.flush_all       = v.flush;
        bp.lookup_pc       = v.lpc;
        bp.upd_en          = v.uen;
        bp.upd_pc          = v.upc;
        bp.upd_taken       = v.utk;
        bp.upd_target      = v.utgt;
        bp.upd_pred_taken  = v.upt;
        bp.upd_pred_target = v.uptgt;
        #1;
        nvec++;
        if (bp.pred_taken !== v.e_pt) begin
            nerr++;
            $display("FAIL %s pred_taken got %b want %b", name, bp.pred_taken, v.e_pt);
        end
        if (bp.pred_target !== v.e_tgt) begin
            nerr++;
            $display("FAIL %s pred_target got %h want %h", name, bp.pred_target, v.e_tgt);
        end
        if (bp.mispredict !== v.e_mp) begin
            nerr++;
            $display("FAIL %s mispredict got %b want %b", name, bp.mispredict, v.e_mp);
        end
        if (bp.miss_count !== v.e_mc) begin
            nerr++;
            $display("FAIL %s miss_count got %0d want %0d", name, bp.miss_count, v.e_mc);
        end
        @(posedge CLK);
        #1;
    endtask

    vec_t tbl [25];

    initial begin
        nvec = 0;
        nerr = 0;
        nRST = 1'b0;
        bp.flush_all = 1'b0;
        bp.lookup_pc = 32'h40;
        bp.upd_en = 1'b0;
        bp.upd_pc = '0;
        bp.upd_taken = 1'b0;
        bp.upd_target = '0;
        bp.upd_pred_taken = 1'b0;
        bp.upd_pred_target = '0;
        repeat (2) @(posedge CLK);
        #1;

        //             nrst fl  lpc     uen upc     tk  utgt    pt  ptgt    e_pt e_tgt  mp  mc
        tbl[0]  = mk(1, 0, 32'h40,  0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h44,  0, 0);
        tbl[1]  = mk(1, 0, 32'h40,  1, 32'h40,  1, 32'h100, 0, 32'h0,   0, 32'h44,  1, 0);
        tbl[2]  = mk(1, 0, 32'h40,  0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h100, 0, 1);
        tbl[3]  = mk(1, 0, 32'h40,  1, 32'h40,  1, 32'h100, 1, 32'h100, 1, 32'h100, 0, 1);
        tbl[4]  = mk(1, 0, 32'h40,  1, 32'h40,  1, 32'h100, 1, 32'h100, 1, 32'h100, 0, 1);
        tbl[5]  = mk(1, 0, 32'h40,  1, 32'h40,  0, 32'h0,   1, 32'h100, 1, 32'h100, 1, 1);
        tbl[6]  = mk(1, 0, 32'h40,  1, 32'h40,  0, 32'h0,   1, 32'h100, 1, 32'h100, 1, 2);
        tbl[7]  = mk(1, 0, 32'h40,  0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h44,  0, 3);
        tbl[8]  = mk(1, 0, 32'h40,  1, 32'h40,  1, 32'h100, 0, 32'h0,   0, 32'h44,  1, 3);
        tbl[9]  = mk(1, 0, 32'h40,  1, 32'h40,  1, 32'h200, 1, 32'h100, 1, 32'h100, 1, 4);
        tbl[10] = mk(1, 0, 32'h40,  0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h200, 0, 5);
        tbl[11] = mk(1, 0, 32'h40,  1, 32'h80,  1, 32'h300, 0, 32'h0,   1, 32'h200, 1, 5);
        tbl[12] = mk(1, 0, 32'h40,  0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h44,  0, 6);
        tbl[13] = mk(1, 0, 32'h80,  0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h300, 0, 6);
        tbl[14] = mk(1, 0, 32'hC4,  1, 32'hC4,  0, 32'h0,   0, 32'h0,   0, 32'hC8,  0, 6);
        tbl[15] = mk(1, 0, 32'hC4,  0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'hC8,  0, 6);
        tbl[16] = mk(1, 0, 32'h83,  0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h300, 0, 6);
        tbl[17] = mk(1, 1, 32'h80,  1, 32'h104, 1, 32'h500, 0, 32'h0,   1, 32'h300, 1, 6);
        tbl[18] = mk(1, 0, 32'h104, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h108, 0, 7);
        tbl[19] = mk(1, 0, 32'h80,  0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h84,  0, 7);
        tbl[20] = mk(1, 0, 32'h200, 1, 32'h200, 1, 32'h600, 0, 32'h0,   0, 32'h204, 1, 7);
        tbl[21] = mk(1, 0, 32'h200, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h600, 0, 8);
        tbl[22] = mk(0, 0, 32'h200, 1, 32'h300, 1, 32'h700, 0, 32'h0,   0, 32'h204, 1, 8);
        tbl[23] = mk(1, 0, 32'h300, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h304, 0, 0);
        tbl[24] = mk(1, 0, 32'h200, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h204, 0, 0);

        for (int i = 0; i < 25; i++)
            step($sformatf("tbl%0d", i), tbl[i]);

        // Counter saturates at 0 and climbs back one step at a time
        step("sat0_alloc", mk(1, 0, 32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h0, 0, 32'h44,  1, 0));
        step("sat0_nt1",   mk(1, 0, 32'h40, 1, 32'h40, 0, 32'h0,   0, 32'h0, 1, 32'h100, 0, 1));
        step("sat0_nt2",   mk(1, 0, 32'h40, 1, 32'h40, 0, 32'h0,   0, 32'h0, 0, 32'h44,  0, 1));
        step("sat0_nt3",   mk(1, 0, 32'h40, 1, 32'h40, 0, 32'h0,   0, 32'h0, 0, 32'h44,  0, 1));
        step("sat0_tk1",   mk(1, 0, 32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h0, 0, 32'h44,  1, 1));
        step("sat0_chk",   mk(1, 0, 32'h40, 0, 32'h0,  0, 32'h0,   0, 32'h0, 0, 32'h44,  0, 2));
        step("sat0_tk2",   mk(1, 0, 32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h0, 0, 32'h44,  1, 2));

        // Standalone flush drops a live entry
        step("flush_pre",  mk(1, 1, 32'h40, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 32'h100, 0, 3));
        step("flush_post", mk(1, 0, 32'h40, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h44,  0, 3));

        // Mispredict stays combinational while reset is held
        step("rst_mp",     mk(0, 0, 32'h40, 1, 32'h40, 0, 32'h0, 1, 32'h0, 0, 32'h44, 1, 3));
        step("rst_after",  mk(1, 0, 32'h40, 0, 32'h0,  0, 32'h0, 0, 32'h0, 0, 32'h44, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
